// File: rtl/traffic_generator_pkg.sv
// Shared types and widths for the traffic generator burst scheduler.
// Holds the scheduler state encoding and the default counter/PTP field widths.
package traffic_generator_pkg;

    localparam int TGEN_CNT_WIDTH  = 32;
    localparam int TGEN_SEC_WIDTH  = 48;
    localparam int TGEN_NSEC_WIDTH = 30;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } tgen_sched_state_t;

endpackage

// File: rtl/tgen_gap_timer.sv
// Loadable down-counter timing the idle gap between bursts.
// expired flags the final cycle of the loaded gap so the scheduler can leave GAP on it.
module tgen_gap_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/traffic_generator_burst_scheduler.sv
// Burst scheduler: one frame request per frame, idle gap after each burst, stop at total.
// Optional first-ack PTP timestamp capture is built when TGEN_SCHED_TIMESTAMP_EN is defined.
module traffic_generator_burst_scheduler
    import traffic_generator_pkg::*;
#(
    parameter int CNT_WIDTH = TGEN_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       run,
    input  logic [CNT_WIDTH-1:0]       frames_per_burst,
    input  logic [CNT_WIDTH-1:0]       interburst_gap,
    input  logic [CNT_WIDTH-1:0]       total_frames,
`ifdef TGEN_SCHED_TIMESTAMP_EN
    input  logic [TGEN_SEC_WIDTH-1:0]  sec,
    input  logic [TGEN_NSEC_WIDTH-1:0] nsec,
    output logic [TGEN_SEC_WIDTH-1:0]  first_sec,
    output logic [TGEN_NSEC_WIDTH-1:0] first_nsec,
`endif
    output logic                       frame_req,
    input  logic                       frame_ack,
    input  logic                       frame_done,
    output logic [CNT_WIDTH-1:0]       frames_sent,
    output logic [CNT_WIDTH-1:0]       bursts_sent,
    output logic                       busy,
    output logic                       done
);

    tgen_sched_state_t    state, next_state;
    logic [CNT_WIDTH-1:0] burst_cnt;
    logic [CNT_WIDTH-1:0] frames_next, burst_next;
    logic                 accept, clear_cnt, count_frame, close_burst;
    logic                 gap_load, gap_expired;

    // An ack only counts once the engine can actually see frame_req high.
    assign accept      = (state == ST_REQ) && frame_req && frame_ack;
    assign frames_next = frames_sent + CNT_WIDTH'(1);
    assign burst_next  = burst_cnt + CNT_WIDTH'(1);
    // A frame already in flight must finish counting before run low wipes the totals.
    assign clear_cnt   = !run && (state != ST_WAIT_DONE);

    tgen_gap_timer #(.WIDTH(CNT_WIDTH)) u_gap_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (gap_load),
        .value   (interburst_gap),
        .expired (gap_expired)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        count_frame = 1'b0;
        close_burst = 1'b0;
        gap_load    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run && ((total_frames == '0) || (frames_sent < total_frames)))
                    next_state = ST_REQ;
            end
            ST_REQ: begin
                if (accept)    next_state = ST_WAIT_DONE;
                else if (!run) next_state = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (frame_done) begin
                    count_frame = 1'b1;
                    if ((total_frames != '0) && (frames_next == total_frames)) begin
                        close_burst = 1'b1;
                        next_state  = ST_DONE;
                    end else if (!run) begin
                        next_state = ST_IDLE;
                    end else if ((frames_per_burst != '0) && (burst_next >= frames_per_burst)) begin
                        close_burst = 1'b1;
                        if (interburst_gap == '0) begin
                            next_state = ST_REQ;
                        end else begin
                            gap_load   = 1'b1;
                            next_state = ST_GAP;
                        end
                    end else begin
                        next_state = ST_REQ;
                    end
                end
            end
            ST_GAP: begin
                if (!run)             next_state = ST_IDLE;
                else if (gap_expired) next_state = ST_REQ;
            end
            ST_DONE: begin
                if (!run) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // frame_req follows state by one cycle, so it only rises after a full REQ cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            frame_req   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            bursts_sent <= '0;
            burst_cnt   <= '0;
        end else begin
            state     <= next_state;
            frame_req <= (state == ST_REQ) && (next_state == ST_REQ);
            busy      <= next_state inside {ST_REQ, ST_WAIT_DONE, ST_GAP};
            done      <= (next_state == ST_DONE);
            if (clear_cnt) begin
                frames_sent <= '0;
                bursts_sent <= '0;
                burst_cnt   <= '0;
            end else if (count_frame) begin
                frames_sent <= frames_next;
                if (close_burst) begin
                    bursts_sent <= bursts_sent + CNT_WIDTH'(1);
                    burst_cnt   <= '0;
                end else begin
                    burst_cnt <= burst_next;
                end
            end
        end
    end

`ifdef TGEN_SCHED_TIMESTAMP_EN
    logic ts_captured;

    // Re-armed on each IDLE->REQ start; the old capture stays visible until replaced.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_captured <= 1'b0;
            first_sec   <= '0;
            first_nsec  <= '0;
        end else if ((state == ST_IDLE) && (next_state == ST_REQ)) begin
            ts_captured <= 1'b0;
        end else if (accept && !ts_captured) begin
            ts_captured <= 1'b1;
            first_sec   <= sec;
            first_nsec  <= nsec;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_generator_burst_scheduler.sv
// Randomized scoreboard bench for traffic_generator_burst_scheduler with a behavioural engine.
// Expected per-frame counters and request latencies come from burst arithmetic on the config.
module tb_traffic_generator_burst_scheduler;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [31:0] frames_per_burst;
    logic [31:0] interburst_gap;
    logic [31:0] total_frames;
    logic        frame_req;
    logic        frame_ack;
    logic        frame_done;
    logic [31:0] frames_sent;
    logic [31:0] bursts_sent;
    logic        busy;
    logic        done;
`ifdef TGEN_SCHED_TIMESTAMP_EN
    logic [47:0] sec;
    logic [29:0] nsec;
    logic [47:0] first_sec;
    logic [29:0] first_nsec;
`endif

    traffic_generator_burst_scheduler #(.CNT_WIDTH(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .run              (run),
        .frames_per_burst (frames_per_burst),
        .interburst_gap   (interburst_gap),
        .total_frames     (total_frames),
`ifdef TGEN_SCHED_TIMESTAMP_EN
        .sec              (sec),
        .nsec             (nsec),
        .first_sec        (first_sec),
        .first_nsec       (first_nsec),
`endif
        .frame_req        (frame_req),
        .frame_ack        (frame_ack),
        .frame_done       (frame_done),
        .frames_sent      (frames_sent),
        .bursts_sent      (bursts_sent),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        int frames;
        int bursts;
        bit last;
        int latency;
    } exp_t;

    exp_t sb_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;
    bit   sb_active = 1'b0;
    bit   lat_pending = 1'b0;
    int   lat_cnt = 0;
    int   lat_exp = 0;
    int   accepts = 0;
    bit   engine_en = 1'b0;
    bit   engine_busy = 1'b0;
    int   ack_max = 0;
    int   done_min = 1;
    int   done_max = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Frame i of a run: counters after its frame_done and cycles until the next request.
    task automatic push_expected(int fpb, int gap, int total, int n);
        for (int i = 1; i <= n; i++) begin
            exp_t e;
            e.frames = i;
            e.last   = (total != 0) && (i == total);
            if (e.last) e.bursts = (fpb == 0) ? 1 : (i + fpb - 1) / fpb;
            else        e.bursts = (fpb == 0) ? 0 : i / fpb;
            if (e.last)                          e.latency = -1;
            else if ((fpb != 0) && (i % fpb == 0)) e.latency = 1 + gap;
            else                                 e.latency = 1;
            sb_q.push_back(e);
        end
    endtask

    // Engine model: accepts a visible request after 0..ack_max cycles, finishes done_min..done_max later.
    initial begin
        frame_ack  = 1'b0;
        frame_done = 1'b0;
        forever begin
            @(negedge clk);
            if (engine_en && frame_req) begin
                engine_busy = 1'b1;
                repeat ($urandom_range(ack_max, 0)) @(negedge clk);
                frame_ack = 1'b1;
                @(negedge clk);
                frame_ack = 1'b0;
                repeat ($urandom_range(done_max, done_min) - 1) @(negedge clk);
                frame_done = 1'b1;
                @(negedge clk);
                frame_done = 1'b0;
                engine_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (frame_req && frame_ack) accepts++;
        end
    end

    // Monitor: compares on every frame_done the DUT has just sampled, then times the next request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_active) begin
                if (lat_pending) begin
                    lat_cnt++;
                    if (frame_req) begin
                        check("req_latency", lat_cnt, lat_exp);
                        lat_pending = 1'b0;
                    end else if (lat_cnt > lat_exp) begin
                        check("req_latency_timeout", lat_cnt, lat_exp);
                        lat_pending = 1'b0;
                    end
                end
                if (frame_done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame_done", frames_sent, 0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("frames_sent", frames_sent, e.frames);
                        check("bursts_sent", bursts_sent, e.bursts);
                        check("done", done, e.last);
                        check("busy", busy, !e.last);
                        if (e.latency >= 0) begin
                            lat_pending = 1'b1;
                            lat_cnt     = 0;
                            lat_exp     = e.latency;
                        end
                    end
                end
            end
        end
    end

    task automatic stop_and_idle();
        int c;
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        c = 0;
        while (engine_busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (engine_busy) check("engine_drain", engine_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frames(logic [31:0] target, int budget, string name);
        int c = 0;
        while (frames_sent != target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (frames_sent != target) check(name, frames_sent, target);
    endtask

    task automatic run_scenario(int fpb, int gap, int total, int n_unl, int a_max, int d_min, int d_max);
        int n;
        int acc0;
        int c;
        n = (total != 0) ? total : n_unl;
        @(negedge clk);
        frames_per_burst = fpb;
        interburst_gap   = gap;
        total_frames     = total;
        ack_max   = a_max;
        done_min  = d_min;
        done_max  = d_max;
        engine_en = 1'b1;
        push_expected(fpb, gap, total, n);
        acc0      = accepts;
        sb_active = 1'b1;
        run       = 1'b1;
        c = 0;
        while ((sb_q.size() != 0 || lat_pending) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        if (sb_q.size() != 0) check("scenario_frames_left", sb_q.size(), 0);
        if (lat_pending) check("scenario_latency_left", lat_pending, 0);
        sb_q.delete();
        sb_active   = 1'b0;
        lat_pending = 1'b0;
        if (total != 0) begin
            repeat (5) @(negedge clk);
            check("accept_count", accepts - acc0, total);
            check("done_held", done, 1);
            check("frame_req_after_done", frame_req, 0);
            check("frames_final", frames_sent, total);
        end
        stop_and_idle();
    endtask

    initial begin
        int a0;
        int c;
        resetn           = 1'b0;
        run              = 1'b0;
        frames_per_burst = '0;
        interburst_gap   = '0;
        total_frames     = '0;
`ifdef TGEN_SCHED_TIMESTAMP_EN
        sec  = '0;
        nsec = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_frame_req", frame_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frames_sent", frames_sent, 0);
        check("rst_bursts_sent", bursts_sent, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed scenarios from the burst rules, then boundary and random configs.
        run_scenario(0, 0, 5, 0, 0, 10, 10);
        run_scenario(3, 20, 7, 0, 2, 1, 6);
        run_scenario(2, 0, 0, 8, 1, 1, 4);
        run_scenario(1, 1, 3, 0, 2, 1, 3);
        run_scenario(4, 2, 1, 0, 0, 1, 1);
        run_scenario(3, 2, 6, 0, 1, 2, 5);
        for (int s = 0; s < 6; s++) begin
            int fpb, gap, total, nu;
            fpb   = $urandom_range(4, 0);
            gap   = ($urandom_range(3, 0) == 0) ? 20 : $urandom_range(5, 0);
            total = $urandom_range(9, 0);
            nu    = $urandom_range(8, 3);
            run_scenario(fpb, gap, total, nu, $urandom_range(2, 0), 1, $urandom_range(12, 1));
        end

        // run falls while a request is pending and the engine withholds ack.
        engine_en        = 1'b0;
        frames_per_burst = 0;
        total_frames     = 0;
        @(negedge clk);
        run = 1'b1;
        @(posedge clk); #1;
        check("req_first_edge", frame_req, 0);
        @(posedge clk); #1;
        check("req_second_edge", frame_req, 1);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk); #1;
        check("req_dropped", frame_req, 0);
        check("req_drop_frames", frames_sent, 0);
        check("req_drop_busy", busy, 0);
        stop_and_idle();

        // A one-cycle run low pulse during a gap clears the counters and re-arms.
        frames_per_burst = 1;
        interburst_gap   = 20;
        total_frames     = 0;
        ack_max   = 0;
        done_min  = 2;
        done_max  = 4;
        engine_en = 1'b1;
        @(negedge clk);
        run = 1'b1;
        wait_frames(2, 400, "pulse_wait_frames");
        check("pulse_bursts_before", bursts_sent, 2);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        check("pulse_frames_cleared", frames_sent, 0);
        check("pulse_bursts_cleared", bursts_sent, 0);
        @(posedge clk); #1;
        check("pulse_rearm_edge1", frame_req, 0);
        @(posedge clk); #1;
        check("pulse_rearm_edge2", frame_req, 1);
        stop_and_idle();

        // Asynchronous reset while a frame is outstanding.
        frames_per_burst = 0;
        total_frames     = 0;
        ack_max   = 0;
        done_min  = 10;
        done_max  = 12;
        @(negedge clk);
        run = 1'b1;
        wait_frames(1, 400, "rstwd_wait_frames");
        a0 = accepts;
        c  = 0;
        while (accepts == a0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (accepts == a0) check("rstwd_accept_wait", accepts - a0, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstwd_frame_req", frame_req, 0);
        check("rstwd_busy", busy, 0);
        check("rstwd_frames_sent", frames_sent, 0);
        check("rstwd_bursts_sent", bursts_sent, 0);
        c = 0;
        while (engine_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rstwd_release_edge1", frame_req, 0);
        @(posedge clk); #1;
        check("rstwd_release_edge2", frame_req, 1);
        stop_and_idle();

        // Asynchronous reset in the middle of an interburst gap.
        frames_per_burst = 1;
        interburst_gap   = 20;
        total_frames     = 0;
        done_min  = 1;
        done_max  = 3;
        @(negedge clk);
        run = 1'b1;
        wait_frames(1, 400, "rstgap_wait_frames");
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rstgap_busy_before", busy, 1);
        check("rstgap_req_low", frame_req, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("rstgap_frame_req", frame_req, 0);
        check("rstgap_busy", busy, 0);
        check("rstgap_frames_sent", frames_sent, 0);
        check("rstgap_bursts_sent", bursts_sent, 0);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        stop_and_idle();

`ifdef TGEN_SCHED_TIMESTAMP_EN
        // First accepted request latches PTP time; later acks leave it alone.
        frames_per_burst = 0;
        total_frames     = 3;
        ack_max   = 2;
        done_min  = 1;
        done_max  = 4;
        sec  = 48'h10;
        nsec = 30'd500;
        @(negedge clk);
        run = 1'b1;
        a0 = accepts;
        c  = 0;
        while (accepts == a0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        sec  = 48'h99;
        nsec = 30'd7;
        wait_frames(3, 400, "ts_wait_frames");
        check("ts_first_sec", first_sec, 48'h10);
        check("ts_first_nsec", first_nsec, 30'd500);
        stop_and_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_generator_burst_scheduler.md
# traffic_generator_burst_scheduler

Sequences the GMII frame engine of the traffic generator into bursts. It issues one frame request per frame and counts completed frames. It inserts a programmable idle gap after every `frames_per_burst` frames and stops after `total_frames`. It sits between the CPU register block (control/burst/total registers) and the frame engine, in the `clk` domain.

## Interface
- `CNT_WIDTH`, 32, width of frame/burst counters and config inputs
- `clk`  in  1  system clock (GMII side)
- `resetn`  in  1  asynchronous active-low reset
- `run`  in  1  level enable (control bit 0, already in `clk` domain)
- `frames_per_burst`  in  CNT_WIDTH  frames per burst; 0 = single endless burst, no interburst gap
- `interburst_gap`  in  CNT_WIDTH  idle cycles between last `frame_done` of a burst and next `frame_req`
- `total_frames`  in  CNT_WIDTH  frames to send; 0 = unlimited
- `frame_req`  out  1  request engine to send one frame
- `frame_ack`  in  1  engine accepted request
- `frame_done`  in  1  one-cycle pulse: frame plus interframe gap finished
- `frames_sent`  out  CNT_WIDTH  completed frames since last `run` low
- `bursts_sent`  out  CNT_WIDTH  completed bursts since last `run` low
- `busy`  out  1  state not IDLE/DONE
- `done`  out  1  `total_frames` reached
- `sec`, `nsec`  in  48, 30  PTP time (only with macro)
- `first_sec`, `first_nsec`  out  48, 30  time of first `frame_ack` (only with macro)

## Operation
- States: IDLE, REQ, WAIT_DONE, GAP, DONE.
- IDLE:
  - `run`=0 → clear `frames_sent`, `bursts_sent`, burst frame count, `done`.
  - `run`=1 and (`total_frames`==0 or `frames_sent`<`total_frames`) → REQ.
- REQ: `frame_req`=1, held until `frame_ack` → WAIT_DONE. If `run` falls before ack → IDLE and deassert `frame_req`; no frame is counted.
- WAIT_DONE: on `frame_done`, increment `frames_sent` and the burst count. Next-state priority:
  1. `total_frames`≠0 and new count == `total_frames` → DONE; burst counted if partial.
  2. `run`=0 → IDLE.
  3. `frames_per_burst`≠0 and burst count reaches it → `bursts_sent`+1, clear burst count; then `interburst_gap`==0 → REQ, else load gap counter and go to GAP.
  4. Otherwise → REQ.
- GAP: decrement each cycle; → REQ when counter reaches 1. `run`=0 → IDLE.
- DONE: `done`=1, no requests; stays until `run`=0 → IDLE. Re-arming requires `run` low then high.
- `frame_ack` and `frame_done` are ignored outside REQ and WAIT_DONE respectively.
- `frames_per_burst` and `total_frames` are sampled live. `interburst_gap` is latched on GAP entry.
- Counters wrap modulo 2^CNT_WIDTH when `total_frames`=0.

## Timing
- All outputs registered. Reset values: all outputs 0; state IDLE.
- `run` sampled high at edge k → `frame_req` high after edge k+1.
- `frame_done` sampled at edge k, no gap → `frame_req` high after edge k+1.
- Interburst gap G>0 → `frame_req` high after edge k+1+G (exactly G idle cycles).
- `frames_sent` and `bursts_sent` update on the edge that samples `frame_done`.
- `frame_ack` coincident with `frame_req` rising is legal. Minimum 1 cycle from accept to next request.
- Async reset mid-frame drops `frame_req` immediately. The engine is reset by the same `resetn`.

## Configuration
- `TGEN_SCHED_TIMESTAMP_EN` defined:
  - `sec`/`nsec` are captured into `first_sec`/`first_nsec` on the first `frame_ack` after leaving IDLE.
  - Captured values hold until the next IDLE→REQ transition.
- Undefined: `sec`/`nsec`/`first_*` ports are absent; no capture registers are built.

## Structure
- Shared package `traffic_generator_pkg`: state enum `tgen_sched_state_t`, `TGEN_CNT_WIDTH`=32, `TGEN_SEC_WIDTH`=48, `TGEN_NSEC_WIDTH`=30.
- One sub-module: `tgen_gap_timer` (loadable down-counter with `load`, `value`, `expired`), used for GAP.

## Test plan
- `frames_per_burst`=0, `total_frames`=5, engine acks immediately, `frame_done` 10 cycles after ack → exactly 5 `frame_req` accepts, `frames_sent`=5, `done`=1, `bursts_sent`=1.
- `frames_per_burst`=3, `interburst_gap`=20, `total_frames`=7 → gaps of exactly 20 idle cycles after frames 3 and 6; `bursts_sent`=3; DONE after frame 7.
- `frames_per_burst`=2, `interburst_gap`=0, `total_frames`=0 → back-to-back requests 1 cycle after each `frame_done`; `bursts_sent` increments every 2 frames.
- `run` dropped while in REQ with ack withheld → `frame_req` low next cycle, `frames_sent` unchanged. `run` low for 1 cycle → counters cleared.
- `resetn` asserted in WAIT_DONE and in GAP → outputs 0 asynchronously. After release with `run`=1, `frame_req` rises 2 edges later.
- With `TGEN_SCHED_TIMESTAMP_EN`: `sec`=0x10, `nsec`=500 at first ack → `first_sec`=0x10, `first_nsec`=500, unchanged by later acks.
